imem_loader: RTL and testbench

- Write-side counterpart of the instruction fetch stage.
- Accepts a byte stream over a valid/ready handshake and assembles it into INSTR_SIZE-bit instruction words.
- Writes each word into the instruction memory write port at consecutive addresses from 0.
- Holds the core (cpu_hold) until a complete program image has been loaded, replacing file preload for in-system program download.

---
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles MSB-first bytes into instruction words
// and writes them to the instruction memory from address 0, holding the core until done.
module imem_loader #(
  parameter int SIZE          = 32,
  parameter int INSTR_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH:0]   mem_addr,
  output logic [INSTR_SIZE-1:0]    mem_wdata,
  output logic [ADDRESS_WIDTH:0]   words_loaded,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_hold
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_LEN   | waiting for the length byte N
  // S_DATA  | collecting bytes of the current word
  // S_WRITE | one-cycle memory write of the assembled word
  // S_DONE  | image loaded, core released
  // S_ERR   | bad length header, core held

  localparam int BPW = INSTR_SIZE / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [7:0]     SIZE_B    = 8'(SIZE);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t                  state, state_n;
  logic [7:0]              len_q;
  logic [BCW-1:0]          byte_cnt;
  logic [INSTR_SIZE-1:0]   asm_q;
  logic [INSTR_SIZE-1:0]   asm_shift;
  logic [8:0]              wl_next;
  logic                    xfer;

  assign xfer      = in_valid & in_ready;
  assign asm_shift = (asm_q << 8) | INSTR_SIZE'(in_data);
  assign wl_next   = 9'(words_loaded) + 9'd1;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LEN;
      S_LEN: if (xfer) state_n = (in_data == 8'd0 || in_data > SIZE_B) ? S_ERR : S_DATA;
      S_DATA: if (xfer && byte_cnt == LAST_BYTE) state_n = S_WRITE;
      S_WRITE: state_n = (wl_next == {1'b0, len_q}) ? S_DONE : S_DATA;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
      len_q        <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == S_LEN) || (state_n == S_DATA);
      busy     <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_WRITE);
      done     <= (state_n == S_DONE);
      error    <= (state_n == S_ERR);
      cpu_hold <= (state_n != S_DONE);
      mem_we   <= (state_n == S_WRITE);

      if (state_n == S_LEN && state != S_LEN) begin
        words_loaded <= '0;
        byte_cnt     <= '0;
        asm_q        <= '0;
      end
      if (state == S_LEN && xfer) len_q <= in_data;
      if (state == S_DATA && xfer) begin
        asm_q    <= asm_shift;
        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BCW'(1);
      end
      if (state == S_DATA && state_n == S_WRITE) begin
        mem_addr  <= words_loaded;
        mem_wdata <= asm_shift;
      end
      if (state == S_WRITE) words_loaded <= words_loaded + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized images, expected writes derived
// from the stream format, checked by an independent write monitor.
module tb_imem_loader;
  localparam int SIZE = 32;
  localparam int INSTR_SIZE = 32;
  localparam int AW = 6;
  localparam int BPW = INSTR_SIZE / 8;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, mem_we, busy, done, error, cpu_hold;
  logic [AW:0] mem_addr, words_loaded;
  logic [INSTR_SIZE-1:0] mem_wdata;

  imem_loader #(.SIZE(SIZE), .INSTR_SIZE(INSTR_SIZE), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_loaded(words_loaded), .busy(busy), .done(done), .error(error),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0] addr;
    logic [INSTR_SIZE-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got write addr %0d data %0h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_mem_we", 64'(mem_we), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_mem_wdata", 64'(mem_wdata), 0);
    check("rst_words_loaded", 64'(words_loaded), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_cpu_hold", 64'(cpu_hold), 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input bit with_start);
    int cnt;
    repeat ($urandom_range(gmax, gmin)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    cnt = 0;
    while (!in_ready && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL byte_accept_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
      in_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_session(input int n, input logic [7:0] data[$], input int gmin, input int gmax,
                             input int start_at, input int stop_after);
    int nbytes, cnt;
    bit bad;
    bad = (n == 0) || (n > SIZE);
    nbytes = (stop_after >= 0) ? stop_after : n * BPW;
    if (!bad) begin
      for (int w = 0; w < nbytes / BPW; w++) begin
        wr_t e;
        e.addr = AW'(w);
        e.data = '0;
        for (int k = 0; k < BPW; k++) e.data = (e.data << 8) | INSTR_SIZE'(data[w * BPW + k]);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy", 64'(busy), 1);
    check("start_cpu_hold", 64'(cpu_hold), 1);
    check("start_done", 64'(done), 0);
    check("start_error", 64'(error), 0);
    check("start_words_loaded", 64'(words_loaded), 0);
    send_byte(8'(n), gmin, gmax, 1'b0);
    if (bad) begin
      cnt = 0;
      while (!error && cnt < 20) begin @(posedge clk); #1; cnt++; end
      check("err_error", 64'(error), 1);
      check("err_cpu_hold", 64'(cpu_hold), 1);
      check("err_busy", 64'(busy), 0);
      check("err_done", 64'(done), 0);
      return;
    end
    for (int i = 0; i < nbytes; i++) begin
      send_byte(data[i], gmin, gmax, i == start_at);
      if (i % BPW == BPW - 1) begin
        check("write_latency_we", 64'(mem_we), 1);
        check("write_in_ready", 64'(in_ready), 0);
      end
    end
    if (stop_after >= 0) return;
    cnt = 0;
    while (!done && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("done_done", 64'(done), 1);
    check("done_cpu_hold", 64'(cpu_hold), 0);
    check("done_busy", 64'(busy), 0);
    check("done_error", 64'(error), 0);
    check("done_in_ready", 64'(in_ready), 0);
    check("done_words_loaded", 64'(words_loaded), 64'(n));
    check("done_pending_writes", 64'(exp_q.size()), 0);
  endtask

  initial begin
    logic [7:0] img[$];
    logic [7:0] none[$];
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst = 1'b0;

    // Basic load, then the same image throttled by 3 idle cycles per byte.
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
    run_session(2, img, 0, 0, -1, -1);
    run_session(2, img, 3, 3, -1, -1);

    // Bytes offered in DONE must not be consumed.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("done_hold_words_loaded", 64'(words_loaded), 2);
    check("done_hold_done", 64'(done), 1);

    // Bad headers, then a good one-word image.
    run_session(0, none, 0, 1, -1, -1);
    check("err_hold_words_loaded", 64'(words_loaded), 0);
    run_session(SIZE + 1, none, 0, 1, -1, -1);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_session(1, img, 0, 1, -1, -1);

    // Full size image.
    img.delete();
    for (int i = 0; i < SIZE * BPW; i++) img.push_back(8'($urandom));
    run_session(SIZE, img, 0, 0, -1, -1);

    // Reset mid-word: two words written, the partial third discarded.
    img.delete();
    for (int i = 0; i < 3 * BPW; i++) img.push_back(8'($urandom));
    run_session(3, img, 0, 1, -1, 2 * BPW + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("rst_no_pending", 64'(exp_q.size()), 0);
    check("rst_still_idle", 64'(busy), 0);
    run_session(3, img, 0, 1, -1, -1);

    // Reload from DONE with a start pulse landing mid-session.
    img.delete();
    for (int i = 0; i < 4 * BPW; i++) img.push_back(8'($urandom));
    run_session(4, img, 0, 2, 5, -1);

    // Randomized sessions, including occasional bad headers.
    for (int s = 0; s < 8; s++) begin
      n = ($urandom_range(4, 0) == 0) ? int'($urandom_range(40, 0)) : int'($urandom_range(SIZE, 1));
      img.delete();
      for (int i = 0; i < n * BPW; i++) img.push_back(8'($urandom));
      run_session(n, img, 0, $urandom_range(3, 0), -1, -1);
    end

    repeat (3) @(posedge clk);
    #1 check("final_no_pending", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
